// File: rtl/tqvp_stevej_wdt_pkg.sv
// Shared types and constants for the watchdog escalator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tqvp_stevej_wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARN    = 2'd1,
        ST_RESET   = 2'd2,
        ST_HOLDOFF = 2'd3
    } wdt_state_e;

    localparam logic [1:0] CFG_GRACE       = 2'd0;
    localparam logic [1:0] CFG_PULSE       = 2'd1;
    localparam logic [1:0] CFG_HOLDOFF     = 2'd2;
    localparam logic [1:0] CFG_CLEAR_COUNT = 2'd3;

    localparam int DEF_GRACE   = 1000;
    localparam int DEF_PULSE   = 16;
    localparam int DEF_HOLDOFF = 64;

endpackage

// File: rtl/tqvp_stevej_wdt_downcnt.sv
// Loadable down-counter that sticks at zero; zero flag is combinational.
// Latency: load/decrement visible one cycle later.
// Backpressure: none.
module tqvp_stevej_wdt_downcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tqvp_stevej_wdt_escalator.sv
// Escalates a watchdog expiry: warning irq, then a timed reset pulse, then a holdoff.
// Latency: WARN entered one cycle after the expired rising edge; outputs registered.
// Backpressure: none; config writes always accepted.
module tqvp_stevej_wdt_escalator
    import tqvp_stevej_wdt_pkg::*;
#(
    parameter int GRACE_W = 16,
    parameter int PULSE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               expired,
    input  logic               pat_seen,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [GRACE_W-1:0] cfg_data,
    output logic               irq,
    output logic               sys_rst,
    output logic [1:0]         state,
    output logic [7:0]         expire_count
);

    wdt_state_e         state_q, state_d;
    logic               expired_q;
    logic               rise;
    logic [GRACE_W-1:0] grace_q;
    logic [PULSE_W-1:0] pulse_q;
    logic [GRACE_W-1:0] holdoff_q;

    logic               cnt_load;
    logic [GRACE_W-1:0] cnt_load_val;
    logic               cnt_en;
    logic [GRACE_W-1:0] cnt;
    logic               cnt_zero;
    logic               cnt_le1;
    logic               inc_count;

    assign rise    = expired & ~expired_q;
    assign cnt_le1 = (cnt <= GRACE_W'(1));

    tqvp_stevej_wdt_downcnt #(.W(GRACE_W)) u_downcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        inc_count    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_WARN;
                    cnt_load     = 1'b1;
                    cnt_load_val = grace_q;
                end
            end
            ST_WARN: begin
                // A pat on the final grace cycle still rescues the system.
                if (pat_seen) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d      = ST_RESET;
                    cnt_load     = 1'b1;
                    cnt_load_val = GRACE_W'(pulse_q);
                    inc_count    = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RESET: begin
                // Leaving at <=1 gives PULSE cycles, and still one cycle for PULSE=0.
                if (cnt_le1) begin
                    state_d      = ST_HOLDOFF;
                    cnt_load     = 1'b1;
                    cnt_load_val = holdoff_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            expired_q <= 1'b0;
            irq       <= 1'b0;
            sys_rst   <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= expired;
            irq       <= (state_d == ST_WARN);
            sys_rst   <= (state_d == ST_RESET);
        end
    end

    // Config only feeds the counter load values, so running counts are never disturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grace_q   <= GRACE_W'(DEF_GRACE);
            pulse_q   <= PULSE_W'(DEF_PULSE);
            holdoff_q <= GRACE_W'(DEF_HOLDOFF);
        end else if (cfg_wr) begin
            unique case (cfg_addr)
                CFG_GRACE:   grace_q   <= cfg_data;
                CFG_PULSE:   pulse_q   <= cfg_data[PULSE_W-1:0];
                CFG_HOLDOFF: holdoff_q <= cfg_data;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expire_count <= '0;
        end else if (cfg_wr && (cfg_addr == CFG_CLEAR_COUNT)) begin
            expire_count <= '0;
        end else if (inc_count && (expire_count != 8'hFF)) begin
            expire_count <= expire_count + 8'd1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_tqvp_stevej_wdt_escalator.sv
// Directed bench for the watchdog escalator with hand-computed expectations.
module tb_tqvp_stevej_wdt_escalator;

    logic        clk;
    logic        rst;
    logic        expired;
    logic        pat_seen;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        irq;
    logic        sys_rst;
    logic [1:0]  state;
    logic [7:0]  expire_count;

    int n_chk  = 0;
    int n_pass = 0;
    int ni, nr, nh, first_irq, nbad;

    tqvp_stevej_wdt_escalator #(.GRACE_W(16), .PULSE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .expired      (expired),
        .pat_seen     (pat_seen),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .irq          (irq),
        .sys_rst      (sys_rst),
        .state        (state),
        .expire_count (expire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // Runs n cycles, tallying irq/sys_rst/holdoff cycles and output/state disagreements.
    task automatic run(input int n, output int o_ni, output int o_nr, output int o_nh,
                       output int o_first, output int o_bad);
        o_ni = 0; o_nr = 0; o_nh = 0; o_first = -1; o_bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (irq) begin
                o_ni++;
                if (o_first < 0) o_first = i;
            end
            if (sys_rst) o_nr++;
            if (state == 2'd3) o_nh++;
            if ((irq != (state == 2'd1)) || (sys_rst != (state == 2'd2))) o_bad++;
        end
    endtask

    task automatic retrigger();
        expired = 1'b0;
        tick();
        expired = 1'b1;
    endtask

    initial begin
        rst = 1'b1; expired = 1'b0; pat_seen = 1'b0;
        cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = '0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_irq", irq, 0);
        chk("rst_sysrst", sys_rst, 0);
        chk("rst_count", expire_count, 0);
        rst = 1'b0;
        tick();

        // Pat on the third WARN cycle
        cfg(2'd0, 16'd5);
        expired = 1'b1;
        tick();
        chk("warn_entry", state, 1);
        tick(); tick();
        pat_seen = 1'b1;
        tick();
        pat_seen = 1'b0;
        chk("pat_idle", state, 0);
        run(20, ni, nr, nh, first_irq, nbad);
        chk("pat_no_rst", nr, 0);
        chk("pat_no_rewarn", ni, 0);
        chk("pat_count", expire_count, 0);

        // GRACE=0: pat coincides with the only WARN cycle
        cfg(2'd0, 16'd0);
        retrigger();
        tick();
        chk("g0_warn", state, 1);
        pat_seen = 1'b1;
        tick();
        pat_seen = 1'b0;
        chk("g0_pat_idle", state, 0);
        run(20, ni, nr, nh, first_irq, nbad);
        chk("g0_no_rst", nr, 0);

        // Full sequence 3/4/2
        cfg(2'd0, 16'd3);
        cfg(2'd1, 16'd4);
        cfg(2'd2, 16'd2);
        retrigger();
        run(20, ni, nr, nh, first_irq, nbad);
        chk("seq_first_irq", first_irq, 0);
        chk("seq_irq_cycles", ni, 4);
        chk("seq_rst_cycles", nr, 4);
        chk("seq_hold_cycles", nh, 3);
        chk("seq_end_idle", state, 0);
        chk("seq_count", expire_count, 1);
        chk("seq_out_consistent", nbad, 0);

        // Held expired does not retrigger; a new edge does
        run(20, ni, nr, nh, first_irq, nbad);
        chk("held_no_warn", ni, 0);
        retrigger();
        run(20, ni, nr, nh, first_irq, nbad);
        chk("edge_rewarn", ni, 4);
        chk("edge_count", expire_count, 2);

        // GRACE change mid-WARN only applies at the next load
        cfg(2'd0, 16'd2);
        retrigger();
        tick();
        cfg(2'd0, 16'd7);
        run(20, ni, nr, nh, first_irq, nbad);
        chk("midcfg_remaining_warn", ni, 1);
        retrigger();
        run(20, ni, nr, nh, first_irq, nbad);
        chk("midcfg_new_grace", ni, 8);
        chk("midcfg_count", expire_count, 4);

        // PULSE=0 still yields one sys_rst cycle
        cfg(2'd0, 16'd0);
        cfg(2'd1, 16'd0);
        cfg(2'd2, 16'd0);
        retrigger();
        run(10, ni, nr, nh, first_irq, nbad);
        chk("p0_rst_cycles", nr, 1);
        chk("p0_warn_cycles", ni, 1);
        chk("p0_hold_cycles", nh, 1);
        chk("p0_count", expire_count, 5);

        // Saturation
        for (int k = 0; k < 250; k++) begin
            retrigger();
            run(4, ni, nr, nh, first_irq, nbad);
        end
        chk("sat_reach", expire_count, 255);
        retrigger();
        run(4, ni, nr, nh, first_irq, nbad);
        chk("sat_rst_cycles", nr, 1);
        chk("sat_hold", expire_count, 255);

        // Clear coinciding with WARN->RESET increment
        retrigger();
        tick();
        chk("clr_warn", state, 1);
        cfg(2'd3, 16'd0);
        chk("clr_in_reset", state, 2);
        chk("clr_wins", expire_count, 0);
        run(5, ni, nr, nh, first_irq, nbad);

        // Async reset in the middle of RESET
        cfg(2'd0, 16'd3);
        cfg(2'd1, 16'd4);
        retrigger();
        for (int k = 0; k < 6; k++) tick();
        chk("mid_rst_active", sys_rst, 1);
        chk("mid_count_before", expire_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_sysrst", sys_rst, 0);
        chk("async_state", state, 0);
        chk("async_irq", irq, 0);
        chk("async_count", expire_count, 0);
        tick();
        rst = 1'b0;
        expired = 1'b0;
        run(10, ni, nr, nh, first_irq, nbad);
        chk("post_rst_no_sysrst", nr, 0);
        expired = 1'b1;
        run(1200, ni, nr, nh, first_irq, nbad);
        chk("def_grace_cycles", ni, 1001);
        chk("def_pulse_cycles", nr, 16);
        chk("def_hold_cycles", nh, 65);
        chk("def_count", expire_count, 1);
        chk("def_out_consistent", nbad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
